// File: rtl/univ_shift_pkg.sv
// Shared mode encodings for the universal shift register and its bench.
package univ_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_counter.sv
// Counts shifts within a word; wrap pulses for one cycle when WIDTH shifts have completed.
module usr_bit_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic wrap
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, plus a completed-word pulse.
// Define USR_ROTATE_EN to add the rot input, which makes shifts rotate instead of taking sin.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             word_vld
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             shr_in, shl_in;
    logic             do_shift, do_load;

    // Bits entering at each end: serial input, or the opposite end when rotating.
    always_comb begin
        shr_in = sin;
        shl_in = sin;
`ifdef USR_ROTATE_EN
        if (rot) begin
            shr_in = q_q[0];
            shl_in = q_q[WIDTH-1];
        end
`endif
    end

    always_comb begin
        q_d      = q_q;
        do_shift = 1'b0;
        do_load  = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    q_d      = {shr_in, q_q[WIDTH-1:1]};
                    do_shift = 1'b1;
                end
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], shl_in};
                    do_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d     = pin;
                    do_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    usr_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (do_load),
        .inc  (do_shift),
        .wrap (word_vld)
    );

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized traffic vs a model.
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, sin;
    logic [1:0]   mode;
    logic [W-1:0] pin;
    logic [W-1:0] q;
    logic         sout_msb, sout_lsb, word_vld;
`ifdef USR_ROTATE_EN
    logic         rot;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: integer register value and shifts since last load/reset.
    int   m_val    = 0;
    int   m_shifts = 0;
    logic m_vld    = 1'b0;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sin      (sin),
`ifdef USR_ROTATE_EN
        .rot      (rot),
`endif
        .pin      (pin),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .word_vld (word_vld)
    );

    task automatic step(input bit r, input bit e, input logic [1:0] md, input bit s,
                        input logic [W-1:0] p, input bit ro);
        int feed;
        rst  = r;
        en   = e;
        mode = md;
        sin  = s;
        pin  = p;
`ifdef USR_ROTATE_EN
        rot  = ro;
`endif
        @(posedge clk);
        m_vld = 1'b0;
        if (r) begin
            m_val    = 0;
            m_shifts = 0;
        end else if (e && md == MODE_LOAD) begin
            m_val    = int'(p);
            m_shifts = 0;
        end else if (e && md == MODE_SHL) begin
            feed     = ro ? (m_val / (1 << (W - 1))) : int'(s);
            m_val    = (m_val * 2 + feed) % (1 << W);
            m_shifts = m_shifts + 1;
            m_vld    = (m_shifts % W) == 0;
        end else if (e && md == MODE_SHR) begin
            feed     = ro ? (m_val % 2) : int'(s);
            m_val    = m_val / 2 + feed * (1 << (W - 1));
            m_shifts = m_shifts + 1;
            m_vld    = (m_shifts % W) == 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, MODE_HOLD, 1'b0, '0, 1'b0);
        n_checks++;
        if (q !== 4'b0000 || word_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: q=%b vld=%b expected q=0000 vld=0", q, word_vld);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), 1'b0);
            n_checks++;
            if (q !== 4'b0000 || word_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: q=%b vld=%b expected q=0000 vld=0",
                         i, q, word_vld);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [3:0] s_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] q_exp  [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        logic       v_exp  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, MODE_SHL, s_seq[i][0], '0, 1'b0);
            n_checks++;
            if (q !== q_exp[i] || word_vld !== v_exp[i]) begin
                n_fail++;
                $display("FAIL shift_left[%0d]: q=%b vld=%b expected q=%b vld=%b",
                         i, q, word_vld, q_exp[i], v_exp[i]);
            end
        end
    endtask

    task automatic test_load_shift_right();
        logic [3:0] q_exp [3] = '{4'b1010, 4'b0101, 4'b0010};
        logic       l_exp [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step(1'b0, 1'b1, MODE_LOAD, 1'b1, 4'b1010, 1'b0);
            else        step(1'b0, 1'b1, MODE_SHR, 1'b0, 4'b1111, 1'b0);
            n_checks++;
            if (q !== q_exp[i] || sout_lsb !== l_exp[i] || sout_msb !== q_exp[i][3]
                || word_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL load_shr[%0d]: q=%b lsb=%b msb=%b vld=%b expected q=%b lsb=%b vld=0",
                         i, q, sout_lsb, sout_msb, word_vld, q_exp[i], l_exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, MODE_LOAD, 1'b0, 4'($urandom), 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, MODE_SHL, 1'($urandom), '0, 1'b0);
            n_checks++;
            if (word_vld !== ((i % 4) == 0) || q !== W'(m_val)) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: q=%b vld=%b expected q=%b vld=%b",
                         i, q, word_vld, W'(m_val), (i % 4) == 0);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        step(1'b0, 1'b1, MODE_SHL, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, MODE_SHR, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 1'b1, '0, 1'b0);
        n_checks++;
        if (q !== 4'b0000 || word_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: q=%b vld=%b expected q=0000 vld=0", q, word_vld);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, (i % 2) ? MODE_SHL : MODE_SHR, 1'($urandom), '0, 1'b0);
            n_checks++;
            if (word_vld !== (i == 4) || q !== W'(m_val)) begin
                n_fail++;
                $display("FAIL reset_mid_shift[%0d]: q=%b vld=%b expected q=%b vld=%b",
                         i, q, word_vld, W'(m_val), i == 4);
            end
        end
    endtask

    task automatic test_random();
        bit r, ro;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            ro = 1'b0;
`ifdef USR_ROTATE_EN
            ro = 1'($urandom);
`endif
            step(r, ($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), 4'($urandom), ro);
            n_checks++;
            if (q !== W'(m_val) || word_vld !== m_vld
                || sout_msb !== 1'(m_val >> (W - 1)) || sout_lsb !== 1'(m_val)) begin
                n_fail++;
                $display("FAIL random[%0d]: q=%b vld=%b msb=%b lsb=%b expected q=%b vld=%b",
                         i, q, word_vld, sout_msb, sout_lsb, W'(m_val), m_vld);
            end
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        logic [3:0] q_exp [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      step(1'b0, 1'b1, MODE_LOAD, 1'b0, 4'b1001, 1'b1);
            else if (i < 3)  step(1'b0, 1'b1, MODE_SHL, 1'($urandom), '0, 1'b1);
            else             step(1'b0, 1'b1, MODE_SHR, 1'($urandom), '0, 1'b1);
            n_checks++;
            if (q !== q_exp[i] || word_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL rotate[%0d]: q=%b vld=%b expected q=%b vld=0",
                         i, q, word_vld, q_exp[i]);
            end
        end
    endtask
`endif

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mode = MODE_HOLD;
        sin  = 1'b0;
        pin  = '0;
`ifdef USR_ROTATE_EN
        rot  = 1'b0;
`endif
        test_reset();
        test_shift_left();
        test_load_shift_right();
        test_back_to_back();
        test_reset_mid_word();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
